// File: rtl/md_issue_ctrl.sv
// md_issue_ctrl: D->E issue register for the multiply/divide unit.
// Holds a cycle-accurate shadow of the MDU busy window, stalls Decode on
// HI/LO-class collisions, and cross-checks the shadow against MDU Busy.
module md_issue_ctrl #(
    parameter int unsigned MULT_LAT = 5,
    parameter int unsigned DIV_LAT  = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       d_valid,
    input  logic [3:0] d_op,
    input  logic       e_flush,
    input  logic       mdu_busy,
    output logic       stall,
    output logic [3:0] md_mode,
    output logic       md_hilosel,
    output logic       shadow_busy,
    output logic       sync_err
);

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MFHI  = 4'd5,
        OP_MFLO  = 4'd6,
        OP_MTHI  = 4'd7,
        OP_MTLO  = 4'd8
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_COUNT = 2'd2
    } md_state_e;

    md_state_e  state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] md_mode_q, md_mode_d;
    logic       md_hilosel_q, md_hilosel_d;
    logic       shadow_dly_q;
    logic       sync_err_q;
    logic       e_start;
    logic       busy;

    function automatic logic is_start(input logic [3:0] op);
        return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic is_access(input logic [3:0] op);
        return is_start(op) || (op == OP_MFHI) || (op == OP_MFLO) ||
               (op == OP_MTHI) || (op == OP_MTLO);
    endfunction

    function automatic logic is_div(input logic [3:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    // Issue decision, E-register next state, busy-window counter and FSM next state.
    // ISSUE tracks "start op sits in E", so the FSM state alone encodes
    // shadow_busy = (cnt != 0) | e_start.
    always_comb begin
        e_start      = (state_q == ST_ISSUE);
        busy         = (state_q != ST_IDLE);
        stall        = d_valid && is_access(d_op) && busy;
        md_mode_d    = OP_NONE;
        md_hilosel_d = md_hilosel_q;
        cnt_d        = '0;
        state_d      = ST_IDLE;

        if (!(stall || e_flush || !d_valid)) begin
            md_mode_d    = d_op;
            md_hilosel_d = (d_op == OP_MFHI);
        end

        if (e_start) begin
            cnt_d = is_div(md_mode_q) ? 4'(DIV_LAT - 1) : 4'(MULT_LAT - 1);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 4'd1;
        end

        if (is_start(md_mode_d)) begin
            state_d = ST_ISSUE;
        end else if (cnt_d != '0) begin
            state_d = ST_COUNT;
        end
    end

    // State, counter and E-stage request registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            md_mode_q    <= OP_NONE;
            md_hilosel_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            md_mode_q    <= md_mode_d;
            md_hilosel_q <= md_hilosel_d;
        end
    end

    // MDU Busy is registered on its side, so compare it with last cycle's shadow; sticky error.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shadow_dly_q <= 1'b0;
            sync_err_q   <= 1'b0;
        end else begin
            shadow_dly_q <= busy;
            sync_err_q   <= sync_err_q | (shadow_dly_q != mdu_busy);
        end
    end

    assign md_mode     = md_mode_q;
    assign md_hilosel  = md_hilosel_q;
    assign shadow_busy = busy;
    assign sync_err    = sync_err_q;

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Scoreboard bench for md_issue_ctrl: a cycle-indexed reference model
// pushes per-cycle expectations; a negedge monitor pops and compares.
module tb_md_issue_ctrl;

    localparam int unsigned ML = 5;
    localparam int unsigned DL = 10;

    localparam logic [3:0] NONE  = 4'd0;
    localparam logic [3:0] MULT  = 4'd1;
    localparam logic [3:0] MULTU = 4'd2;
    localparam logic [3:0] DIV   = 4'd3;
    localparam logic [3:0] DIVU  = 4'd4;
    localparam logic [3:0] MFHI  = 4'd5;
    localparam logic [3:0] MFLO  = 4'd6;
    localparam logic [3:0] MTHI  = 4'd7;
    localparam logic [3:0] MTLO  = 4'd8;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       d_valid = 1'b0;
    logic [3:0] d_op = NONE;
    logic       e_flush = 1'b0;
    logic       mdu_busy = 1'b0;
    logic       stall;
    logic [3:0] md_mode;
    logic       md_hilosel;
    logic       shadow_busy;
    logic       sync_err;

    md_issue_ctrl #(.MULT_LAT(ML), .DIV_LAT(DL)) dut (
        .clk(clk), .reset(reset), .d_valid(d_valid), .d_op(d_op),
        .e_flush(e_flush), .mdu_busy(mdu_busy), .stall(stall),
        .md_mode(md_mode), .md_hilosel(md_hilosel),
        .shadow_busy(shadow_busy), .sync_err(sync_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] mode;
        logic       hsel;
        logic       sh;
        logic       st;
        logic       serr;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: HI/LO unavailable for cycles [issue, busy_end).
    int         cyc = 0;
    int         busy_end = 0;
    logic [3:0] m_mode = NONE;
    logic       m_hsel = 1'b0;
    logic       m_serr = 1'b0;
    logic       prev_sh = 1'b0;
    logic       mdu_early = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    function automatic logic is_start(input logic [3:0] op);
        return op inside {MULT, MULTU, DIV, DIVU};
    endfunction

    function automatic logic is_access(input logic [3:0] op);
        return op inside {MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO};
    endfunction

    // One cycle of stimulus; pushes expectations for this cycle, advances the model.
    task automatic step(input logic v, input logic [3:0] op, input logic fl, output logic st);
        logic sh;
        logic mb;
        @(posedge clk);
        #1;
        sh = (cyc < busy_end);
        mb = prev_sh & (mdu_early ? sh : 1'b1);
        d_valid  = v;
        d_op     = op;
        e_flush  = fl;
        mdu_busy = mb;
        st = v & is_access(op) & sh;
        exp_q.push_back('{mode: m_mode, hsel: m_hsel, sh: sh, st: st, serr: m_serr});
        if (mb != prev_sh) m_serr = 1'b1;
        if (st || fl || !v) begin
            m_mode = NONE;
        end else begin
            m_mode = op;
            m_hsel = (op == MFHI);
            if (is_start(op))
                busy_end = cyc + 1 + ((op == DIV || op == DIVU) ? DL : ML);
        end
        prev_sh = sh;
        cyc++;
    endtask

    task automatic idle(input int n);
        logic st;
        for (int i = 0; i < n; i++) step(1'b0, NONE, 1'b0, st);
    endtask

    // Hold an op in D until the model says it is accepted (bounded).
    task automatic issue(input logic [3:0] op);
        logic st;
        int   n;
        n = 0;
        do begin
            step(1'b1, op, 1'b0, st);
            n++;
        end while (st && n < 40);
        if (st) chk("issue_timeout", 1, 0);
    endtask

    task automatic do_reset();
        d_valid  = 1'b0;
        d_op     = NONE;
        e_flush  = 1'b0;
        mdu_busy = 1'b0;
        reset    = 1'b0;
        #1;
        chk("rst_md_mode", int'(md_mode), 0);
        chk("rst_hilosel", int'(md_hilosel), 0);
        chk("rst_shadow", int'(shadow_busy), 0);
        chk("rst_stall", int'(stall), 0);
        chk("rst_sync_err", int'(sync_err), 0);
        repeat (2) @(posedge clk);
        #3;
        reset    = 1'b1;
        m_mode   = NONE;
        m_hsel   = 1'b0;
        m_serr   = 1'b0;
        busy_end = 0;
        prev_sh  = 1'b0;
    endtask

    // Monitor: compare the oldest expectation against the DUT at each falling edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("md_mode", int'(md_mode), int'(e.mode));
            chk("md_hilosel", int'(md_hilosel), int'(e.hsel));
            chk("shadow_busy", int'(shadow_busy), int'(e.sh));
            chk("stall", int'(stall), int'(e.st));
            chk("sync_err", int'(sync_err), int'(e.serr));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic       st;
        logic       hv;
        logic [3:0] hop;
        logic       last_st;

        #2;
        do_reset();
        idle(2);

        // MULT then dependent MFLO.
        issue(MULT);
        issue(MFLO);
        idle(2);

        // DIVU then MFHI.
        issue(DIVU);
        issue(MFHI);
        idle(2);

        // MULT, ADD, ADD, MTLO: non-MDU ops flow during the window.
        issue(MULT);
        step(1'b1, NONE, 1'b0, st);
        step(1'b1, NONE, 1'b0, st);
        issue(MTLO);
        idle(2);

        // Flushed MULT never opens a window.
        step(1'b1, MULT, 1'b1, st);
        issue(MFHI);
        issue(MTHI);
        issue(MFLO);
        idle(2);

        // Reset in the middle of a DIV window.
        issue(DIV);
        idle(4);
        @(posedge clk);
        #2;
        do_reset();
        idle(3);

        // Randomized traffic; a stalled instruction stays in D.
        last_st = 1'b0;
        hv  = 1'b0;
        hop = NONE;
        for (int i = 0; i < 400; i++) begin
            if (!last_st) begin
                hv  = ($urandom_range(0, 3) != 0);
                hop = 4'($urandom_range(0, 8));
            end
            step(hv, hop, ($urandom_range(0, 9) == 0), last_st);
        end
        idle(12);

        // MDU whose Busy falls one cycle early: sticky sync_err.
        mdu_early = 1'b1;
        issue(MULTU);
        idle(12);
        mdu_early = 1'b0;
        idle(3);
        @(posedge clk);
        #2;
        do_reset();
        idle(3);

        @(negedge clk);
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/md_issue_ctrl.md
# md_issue_ctrl

Pipeline-side initiator for the multiply/divide unit (MDU). It sits between Decode and Execute, registers the decoded HI/LO operation into the E-stage request to the MDU, and keeps a cycle-accurate shadow of the MDU's busy window. It stalls Decode whenever an HI/LO-class instruction would collide with an in-flight multiply or divide. It also cross-checks its shadow against the MDU's own Busy flag.

## Interface
Parameters:
- MULT_LAT, 5, cycles HI/LO are unavailable after a MULT/MULTU issue edge
- DIV_LAT, 10, cycles HI/LO are unavailable after a DIV/DIVU issue edge

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low; one clock, reset asserted when reset==0
- d_valid  in  1  Decode holds a valid instruction
- d_op  in  4  decoded MDU op, shared MULDIVMode encoding (NONE, MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO)
- e_flush  in  1  other hazard logic inserts a bubble into E this cycle
- mdu_busy  in  1  Busy flag returned by the MDU
- stall  out  1  freeze PC/F/D and bubble E (combinational)
- md_mode  out  4  registered E-stage mode to the MDU
- md_hilosel  out  1  registered HI/LO read select to the MDU (HIGH for MFHI)
- shadow_busy  out  1  controller's model of the MDU busy window
- sync_err  out  1  sticky: shadow_busy != mdu_busy observed

## Operation
- Classes:
  - start = MULT, MULTU, DIV, DIVU.
  - access = start, MFHI, MFLO, MTHI, MTLO.
- cnt: 4-bit down-counter. shadow_busy = (cnt != 0) | e_start, where e_start = md_mode is start.
- stall = d_valid & (d_op is access) & shadow_busy.
- E register update each edge:
  - stall | e_flush | !d_valid: md_mode <= NONE; md_hilosel holds.
  - otherwise: md_mode <= d_op; md_hilosel <= (d_op==MFHI).
- Counter update each edge:
  - e_start: cnt <= MULT_LAT-1 for mult class, DIV_LAT-1 for div class.
  - otherwise: cnt <= cnt-1, saturating at 0.
- FSM (derived from cnt/e_start): IDLE -> ISSUE (e_start) -> COUNT (cnt!=0) -> IDLE (cnt==0).
  - A new start cannot enter E while shadow_busy is asserted, because stall blocks it, so ISSUE is never re-entered from COUNT.
- Non-MDU instructions in D never stall and flow normally, including during COUNT.
- sync_err: set at any edge where shadow_busy != mdu_busy delayed by one cycle, because the MDU Busy is registered. Cleared only by reset.
- e_flush has priority over issue. A flushed start never loads cnt.

## Timing
- Reset values: md_mode=NONE, md_hilosel=0, cnt=0, shadow_busy=0, stall=0 (absent D input), sync_err=0.
- Reset assertion mid-COUNT clears cnt immediately (async). The first edge after release behaves as IDLE.
- Issue latency: an accepted op appears on md_mode one cycle after it is in D.
- MULT issued at edge t (md_mode=MULT during cycle t..t+1): shadow_busy high for MULT_LAT cycles. A dependent MFLO in D stalls for exactly MULT_LAT cycles after entering D behind it, then issues.
- DIV: same with DIV_LAT.
- Back-to-back MULT, MULT: the second stalls MULT_LAT cycles.
- MTHI/MTLO/MFHI/MFLO issue with no busy window. Consecutive accesses never stall each other.
- Simultaneous e_flush and stall: md_mode=NONE; stall is still driven.

## Test plan
- Reset low mid-DIV (cnt=6) -> cnt=0, shadow_busy=0, md_mode=NONE immediately; sync_err=0 after release.
- MULT then MFLO in consecutive cycles -> stall high exactly 5 cycles; MFLO appears on md_mode, md_hilosel=0, in the cycle after stall falls.
- DIVU then MFHI -> stall high 10 cycles; md_hilosel=1 when MFHI issues.
- MULT then ADD, ADD, MTLO -> ADDs never stall; MTLO stalls until cnt reaches 0.
- MULT in D with e_flush=1 -> md_mode=NONE, cnt stays 0, a following MFHI issues with no stall.
- Model an MDU whose Busy drops one cycle early -> sync_err rises at that edge and stays 1 until reset.
